// File: rtl/smbm_sched.sv
// Round-robin front-end scheduler for the smbm store: one ADD/DELETE/READ in flight, tagged response.
// Optional watchdog on the smbm_done wait is enabled by defining SMBM_SCHED_TIMEOUT_EN.
module smbm_sched #(
    parameter int unsigned NUM_REQ            = 4,
    parameter int unsigned REQ_LOG            = 2,
    parameter int unsigned BIT_VEC_SIZE       = 128,
    parameter int unsigned BIT_VEC_SIZE_LOG   = 7,
    parameter int unsigned NUM_OF_METRICS     = 2,
    parameter int unsigned NUM_OF_METRICS_LOG = 1,
    parameter int unsigned TIMEOUT_CYCLES     = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_REQ-1:0]                              req_valid,
    output logic [NUM_REQ-1:0]                              req_ready,
    input  logic [NUM_REQ-1:0][2:0]                         req_op,
    input  logic [NUM_REQ-1:0][BIT_VEC_SIZE_LOG-1:0]        req_id,
    input  logic [NUM_REQ-1:0][NUM_OF_METRICS-1:0][7:0]     req_metric_val,
    input  logic [NUM_REQ-1:0][BIT_VEC_SIZE-1:0]            req_in,
    input  logic [NUM_REQ-1:0][NUM_OF_METRICS_LOG-1:0]      req_metricX,
    input  logic [NUM_REQ-1:0][2:0]                         req_opcode_in,
    output logic [2:0]                                      smbm_opcode,
    output logic [BIT_VEC_SIZE_LOG-1:0]                     smbm_id,
    output logic [NUM_OF_METRICS-1:0][7:0]                  smbm_metric_val,
    output logic [BIT_VEC_SIZE-1:0]                         smbm_in,
    output logic [NUM_OF_METRICS_LOG-1:0]                   smbm_metricX,
    output logic [2:0]                                      smbm_opcode_in,
    input  logic                                            smbm_done,
    output logic                                            rsp_valid,
    output logic [REQ_LOG-1:0]                              rsp_req,
    output logic [1:0]                                      rsp_status,
    output logic [BIT_VEC_SIZE_LOG:0]                       occupancy
);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpDel  = 3'b001;
    localparam logic [2:0] OpRead = 3'b010;
    localparam logic [2:0] OpNone = 3'b111;

    localparam logic [1:0] StsOk    = 2'b00;
    localparam logic [1:0] StsFull  = 2'b01;
    localparam logic [1:0] StsEmpty = 2'b10;
`ifdef SMBM_SCHED_TIMEOUT_EN
    localparam logic [1:0] StsTimeout = 2'b11;
`endif

    localparam logic [BIT_VEC_SIZE_LOG:0] Capacity = (BIT_VEC_SIZE_LOG + 1)'(BIT_VEC_SIZE);
    localparam logic [REQ_LOG-1:0]        LastReq  = REQ_LOG'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state;
    logic [REQ_LOG-1:0] rr_ptr;
    logic [2:0]         op_latched;
`ifdef SMBM_SCHED_TIMEOUT_EN
    logic [7:0]         wait_cnt;
`endif

    logic               grant_any;
    logic [REQ_LOG-1:0] grant_idx;
    logic [REQ_LOG-1:0] cand;
    logic [REQ_LOG-1:0] ptr_next;
    logic [2:0]         grant_op;
    logic               is_full;
    logic               is_empty;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = REQ_LOG'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == StIdle && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign ptr_next = (grant_idx == LastReq) ? '0 : grant_idx + 1'b1;
    assign grant_op = req_op[grant_idx];
    assign is_full  = (occupancy == Capacity);
    assign is_empty = (occupancy == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= StIdle;
            rr_ptr          <= '0;
            op_latched      <= OpNone;
            smbm_opcode     <= OpNone;
            smbm_id         <= '0;
            smbm_metric_val <= '0;
            smbm_in         <= '0;
            smbm_metricX    <= '0;
            smbm_opcode_in  <= '0;
            rsp_valid       <= 1'b0;
            rsp_req         <= '0;
            rsp_status      <= StsOk;
            occupancy       <= '0;
`ifdef SMBM_SCHED_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    rsp_valid <= 1'b0;
                    if (grant_any) begin
                        smbm_id         <= req_id[grant_idx];
                        smbm_metric_val <= req_metric_val[grant_idx];
                        smbm_in         <= req_in[grant_idx];
                        smbm_metricX    <= req_metricX[grant_idx];
                        smbm_opcode_in  <= req_opcode_in[grant_idx];
                        rsp_req         <= grant_idx;
                        rr_ptr          <= ptr_next;
                        op_latched      <= grant_op;
                        if (grant_op == OpAdd && is_full) begin
                            state      <= StResp;
                            rsp_valid  <= 1'b1;
                            rsp_status <= StsFull;
                        end else if (grant_op == OpDel && is_empty) begin
                            state      <= StResp;
                            rsp_valid  <= 1'b1;
                            rsp_status <= StsEmpty;
                        end else if (grant_op == OpAdd || grant_op == OpDel ||
                                     grant_op == OpRead) begin
                            state       <= StIssue;
                            smbm_opcode <= grant_op;
                        end else begin
                            // Unsupported opcodes are acknowledged without touching smbm.
                            state      <= StResp;
                            rsp_valid  <= 1'b1;
                            rsp_status <= StsOk;
                        end
                    end
                end
                StIssue: begin
                    smbm_opcode <= OpNone;
                    state       <= StWait;
`ifdef SMBM_SCHED_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end
                StWait: begin
                    if (smbm_done) begin
                        state      <= StResp;
                        rsp_valid  <= 1'b1;
                        rsp_status <= StsOk;
                        if (op_latched == OpAdd) begin
                            occupancy <= occupancy + 1'b1;
                        end else if (op_latched == OpDel) begin
                            occupancy <= occupancy - 1'b1;
                        end
`ifdef SMBM_SCHED_TIMEOUT_EN
                    end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        // Gives up after exactly TIMEOUT_CYCLES wait cycles.
                        state      <= StResp;
                        rsp_valid  <= 1'b1;
                        rsp_status <= StsTimeout;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                StResp: begin
                    rsp_valid <= 1'b0;
                    state     <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smbm_sched.sv
// Bench for smbm_sched: transaction-level model plus directed scenarios with literal latencies.
// Define SMBM_SCHED_TIMEOUT_EN to also exercise the watchdog.
module tb_smbm_sched;

    localparam int NUM_REQ = 4;
    localparam int TOUT    = 16;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0][2:0]     req_op = '0;
    logic [NUM_REQ-1:0][6:0]     req_id = '0;
    logic [NUM_REQ-1:0][1:0][7:0] req_metric_val = '0;
    logic [NUM_REQ-1:0][127:0]   req_in = '0;
    logic [NUM_REQ-1:0][0:0]     req_metricX = '0;
    logic [NUM_REQ-1:0][2:0]     req_opcode_in = '0;
    logic [2:0]                  smbm_opcode;
    logic [6:0]                  smbm_id;
    logic [1:0][7:0]             smbm_metric_val;
    logic [127:0]                smbm_in;
    logic [0:0]                  smbm_metricX;
    logic [2:0]                  smbm_opcode_in;
    logic                        smbm_done = 1'b0;
    logic                        rsp_valid;
    logic [1:0]                  rsp_req;
    logic [1:0]                  rsp_status;
    logic [7:0]                  occupancy;

    smbm_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
        .req_metric_val(req_metric_val), .req_in(req_in), .req_metricX(req_metricX),
        .req_opcode_in(req_opcode_in),
        .smbm_opcode(smbm_opcode), .smbm_id(smbm_id), .smbm_metric_val(smbm_metric_val),
        .smbm_in(smbm_in), .smbm_metricX(smbm_metricX), .smbm_opcode_in(smbm_opcode_in),
        .smbm_done(smbm_done),
        .rsp_valid(rsp_valid), .rsp_req(rsp_req), .rsp_status(rsp_status),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // smbm stand-in: READ finishes after one wait cycle, ADD/DELETE after two.
    bit done_tied0 = 1'b0;
    int stub_cnt   = 0;
    always @(negedge clk) begin
        if (rst || done_tied0) begin
            stub_cnt  = 0;
            smbm_done = 1'b0;
        end else if (smbm_opcode == 3'b000 || smbm_opcode == 3'b001 || smbm_opcode == 3'b010) begin
            stub_cnt  = (smbm_opcode == 3'b010) ? 1 : 2;
            smbm_done = 1'b0;
        end else if (stub_cnt != 0) begin
            stub_cnt--;
            smbm_done = (stub_cnt == 0);
        end else begin
            smbm_done = 1'b0;
        end
    end

    // Transaction model: one command in flight, outcome decided at acceptance.
    bit           m_on = 1'b0;
    bit           m_busy = 1'b0;
    int           m_due, m_issue, m_ptr, m_occ, m_req, m_delta, m_win, m_idx;
    logic [2:0]   m_op;
    logic [1:0]   m_st;
    logic [6:0]   m_id;
    logic [15:0]  m_mv;
    logic [127:0] m_in;
    logic         m_mx;
    logic [2:0]   m_oi;
    logic [3:0]   e_ready;
    logic         e_rv;
    logic [2:0]   e_op;

    always @(negedge clk) begin
        e_ready = '0;
        m_win   = -1;
        if (m_on && !m_busy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                m_idx = (m_ptr + k) % NUM_REQ;
                if (m_win < 0 && req_valid[m_idx]) m_win = m_idx;
            end
            if (m_win >= 0) e_ready[m_win] = 1'b1;
        end
        if (m_on) begin
            e_rv = m_busy && (cyc == m_due);
            e_op = (m_busy && cyc == m_issue) ? m_op : 3'b111;
            if (e_rv) m_occ += m_delta;
            chk("req_ready", req_ready, e_ready);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("smbm_opcode", smbm_opcode, e_op);
            chk("occupancy", occupancy, m_occ);
            chk("smbm_id", smbm_id, m_id);
            chk("smbm_metric_val", smbm_metric_val, m_mv);
            chk("smbm_in", smbm_in, m_in);
            chk("smbm_metricX", smbm_metricX, m_mx);
            chk("smbm_opcode_in", smbm_opcode_in, m_oi);
            if (e_rv) begin
                chk("rsp_req", rsp_req, m_req);
                chk("rsp_status", rsp_status, m_st);
                m_busy = 1'b0;
            end
        end
        if (rst) begin
            m_on = 1'b1; m_busy = 1'b0; m_ptr = 0; m_occ = 0; m_issue = -1;
            m_id = '0; m_mv = '0; m_in = '0; m_mx = 1'b0; m_oi = '0;
        end else if (m_on && m_win >= 0) begin
            m_busy = 1'b1;
            m_req  = m_win;
            m_ptr  = (m_win + 1) % NUM_REQ;
            m_op   = req_op[m_win];
            m_id   = req_id[m_win];
            m_mv   = req_metric_val[m_win];
            m_in   = req_in[m_win];
            m_mx   = req_metricX[m_win];
            m_oi   = req_opcode_in[m_win];
            m_issue = -1; m_delta = 0; m_st = 2'b00; m_due = cyc + 1;
            if (m_op == 3'b000 && m_occ == 128) begin
                m_st = 2'b01;
            end else if (m_op == 3'b001 && m_occ == 0) begin
                m_st = 2'b10;
            end else if (m_op <= 3'b010) begin
                m_issue = cyc + 1;
                if (done_tied0) begin
`ifdef SMBM_SCHED_TIMEOUT_EN
                    m_due = cyc + TOUT + 2;
                    m_st  = 2'b11;
`else
                    m_due = cyc + 1000000;
`endif
                end else begin
                    m_due   = cyc + ((m_op == 3'b010) ? 3 : 4);
                    m_delta = (m_op == 3'b000) ? 1 : (m_op == 3'b001) ? -1 : 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [6:0] id,
                           input logic [7:0] m0, input logic [7:0] m1, input logic [127:0] vin,
                           input logic mx, input logic [2:0] oi);
        req_op[r]            = op;
        req_id[r]            = id;
        req_metric_val[r][0] = m0;
        req_metric_val[r][1] = m1;
        req_in[r]            = vin;
        req_metricX[r]       = mx;
        req_opcode_in[r]     = oi;
        req_valid[r]         = 1'b1;
    endtask

    task automatic wait_accept(output int w);
        int n;
        w = -1;
        n = 0;
        while (w < 0 && n < 30) begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) if (req_valid[k] && req_ready[k] && w < 0) w = k;
            n++;
        end
    endtask

    // Waits for a grant, checks the winner, then checks literal latency and status.
    task automatic serve(input int exp_r, input int exp_lat, input logic [1:0] exp_st,
                         input string name);
        int w, acc, n;
        wait_accept(w);
        if (w < 0) begin
            bound_fail({name, " grant"});
            return;
        end
        chk({name, " winner"}, w, exp_r);
        acc = cyc;
        step();
        req_valid[w] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        if (!rsp_valid) begin
            bound_fail({name, " response"});
            return;
        end
        chk({name, " latency"}, cyc - acc, exp_lat);
        chk({name, " status"}, rsp_status, exp_st);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset opcode", smbm_opcode, 3'b111);
        chk("reset occupancy", occupancy, 0);
        chk("reset rsp_req", rsp_req, 0);
        chk("reset rsp_status", rsp_status, 2'b00);
        chk("reset smbm_id", smbm_id, 0);
        chk("reset smbm_in", smbm_in, 0);
    endtask

    initial begin
        int w;
        logic [127:0] pat;
        pat = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init occupancy", occupancy, 0);
        chk("init opcode", smbm_opcode, 3'b111);

        // Single ADD from requester 0.
        step();
        set_req(0, 3'b000, 7'd5, 8'd10, 8'd20, '0, 1'b0, 3'b000);
        serve(0, 4, 2'b00, "add0");
        chk("add0 occupancy", occupancy, 1);
        chk("add0 rsp_req", rsp_req, 0);

        // Three simultaneous requesters, pointer at 1, then wrap to 0.
        step();
        set_req(1, 3'b000, 7'd7, 8'd1, 8'd2, '0, 1'b0, 3'b000);
        set_req(2, 3'b010, 7'd0, 8'd0, 8'd0, pat, 1'b0, 3'b010);
        set_req(3, 3'b001, 7'd5, 8'd0, 8'd0, '0, 1'b0, 3'b000);
        serve(1, 4, 2'b00, "rr1");
        serve(2, 3, 2'b00, "rr2");
        serve(3, 4, 2'b00, "rr3");
        step();
        set_req(0, 3'b011, 7'd0, 8'd0, 8'd0, '0, 1'b0, 3'b000);
        set_req(3, 3'b100, 7'd0, 8'd0, 8'd0, '0, 1'b0, 3'b000);
        serve(0, 1, 2'b00, "wrap0");
        serve(3, 1, 2'b00, "wrap3");
        chk("rr occupancy", occupancy, 1);

        // DELETE when empty is rejected.
        do_reset();
        step();
        set_req(0, 3'b001, 7'd3, 8'd0, 8'd0, '0, 1'b0, 3'b000);
        serve(0, 1, 2'b10, "del_empty");
        chk("del_empty occupancy", occupancy, 0);

        // Fill to capacity, then one ADD too many, then a DELETE.
        for (int i = 0; i < 128; i++) begin
            step();
            set_req(0, 3'b000, 7'(i), 8'(i), 8'(255 - i), '0, 1'b0, 3'b000);
            serve(0, 4, 2'b00, "fill");
        end
        chk("fill occupancy", occupancy, 128);
        step();
        set_req(0, 3'b000, 7'd9, 8'd1, 8'd1, '0, 1'b0, 3'b000);
        serve(0, 1, 2'b01, "add_full");
        chk("add_full occupancy", occupancy, 128);
        step();
        set_req(0, 3'b001, 7'd0, 8'd0, 8'd0, '0, 1'b0, 3'b000);
        serve(0, 4, 2'b00, "del_full");
        chk("del_full occupancy", occupancy, 127);

        // Full READ with metric 1.
        step();
        set_req(2, 3'b010, 7'd0, 8'd0, 8'd0, pat, 1'b1, 3'b101);
        serve(2, 3, 2'b00, "read");
        chk("read opcode_in", smbm_opcode_in, 3'b101);
        chk("read metricX", smbm_metricX, 1'b1);
        chk("read smbm_in", smbm_in, pat);

`ifdef SMBM_SCHED_TIMEOUT_EN
        step();
        done_tied0 = 1'b1;
        set_req(1, 3'b000, 7'd9, 8'd3, 8'd4, '0, 1'b0, 3'b000);
        serve(1, TOUT + 2, 2'b11, "timeout");
        chk("timeout occupancy", occupancy, 127);
`endif

        // Reset in the middle of a stalled command abandons it silently.
        step();
        done_tied0 = 1'b1;
        set_req(3, 3'b000, 7'd11, 8'd5, 8'd6, '0, 1'b0, 3'b000);
        wait_accept(w);
        if (w < 0) bound_fail("midreset grant");
        step();
        req_valid = '0;
        repeat (3) @(negedge clk);
        do_reset();
        repeat (25) @(negedge clk);
        done_tied0 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
